frogger_round_ctrl: RTL and testbench
=====================================

# frogger_round_ctrl

Round/life sequencer for the Frogger game: turns raw game events (frog reaches home row, frog collides, round timer expires) into the single-cycle `win`/`lose` pulses consumed by the score/HEX display block, and gates gameplay between rounds. Sits between the frog/lane logic and the score block on the 50 MHz domain, owning lives, the per-round countdown, respawn sequencing, and game restart on the start key.

## Interface
- `LIVES`, 3: lives per game (≥1)
- `ROUND_TICKS`, 30: `tick` periods allowed per crossing
- `HOLD_TICKS`, 2: `tick` periods of pause after a win or lost life (≥1)

- `clock`  in  1  system clock (CLOCK_50)
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `start`  in  1  synchronized start key level; rising edge used
- `tick`   in  1  one-cycle frame-rate enable
- `frog_home`  in  1  frog occupies home row (level)
- `frog_hit`   in  1  frog collision this cycle (level)
- `game_over`  in  1  score block's 10-win flag
- `win`    out  1  one-cycle pulse to score block
- `lose`   out  1  one-cycle pulse to score block
- `respawn`  out  1  one-cycle pulse: frog to start row, lanes cleared
- `play_en`  out  1  high only in PLAY; gates frog/lane movement
- `lives`  out  $clog2(LIVES+1)  lives remaining
- `time_left`  out  $clog2(ROUND_TICKS+1)  ticks left in round
- `state`  out  3  current state code (debug)

## Operation
- States: IDLE=0, PLAY=1, HOLD=2, DEAD=3, OVER=4.
- `go` = `start & ~start_q`; `start_q` registered each cycle.
- IDLE/DEAD/OVER: `play_en`=0; on `go` → PLAY, `lives`←LIVES, `time_left`←ROUND_TICKS, `respawn` pulse.
- PLAY, priority order each cycle:
  - `frog_hit`, or (`tick` & `time_left`==1) = death: if `lives`==1 → `lives`←0, `lose` pulse, → DEAD; else `lives`−1, → HOLD.
  - else `frog_home` → `win` pulse, → HOLD.
  - else `tick` → `time_left`−1.
- Simultaneous hit and home: death wins, no `win`.
- HOLD: `game_over`=1 → OVER (checked first, every cycle). Else count `tick`s; on HOLD_TICKS-th tick → `respawn` pulse, `time_left`←ROUND_TICKS, → PLAY.
- `win` and `lose` never high in the same cycle; each at most one cycle per event.
- `frog_home`/`frog_hit`/`start` ignored outside the states listed above.

## Timing
- All outputs registered; event in cycle N → pulse and state change visible in cycle N+1.
- `play_en` falls in the same cycle `win`/`lose` rises.
- Score block raises `game_over` one cycle after `win`; HOLD's game_over priority catches it before any exit (HOLD_TICKS≥1).
- Reset values: state IDLE, `win`/`lose`/`respawn`/`play_en`=0, `lives`=LIVES, `time_left`=ROUND_TICKS, hold counter 0, `start_q`=1 (key held through reset is not a start).
- Reset mid-game: immediate return to IDLE with the above values; no pulse emitted.
- `time_left` never wraps: reload occurs on the timeout tick instead of reaching 0 in PLAY.

## Configuration
- `FROGGER_ROUND_TIMER_EN` defined: countdown and timeout death as above.
- Undefined: no timer logic; `time_left` tied to ROUND_TICKS, deaths from `frog_hit` only.

## Test plan
- Reset low 5 cycles, release with `start`=1 held → state 0, no `respawn`; drop and re-raise `start` → `respawn` pulse, state 1, `lives`=3, `time_left`=30.
- In PLAY, pulse `frog_home` → one `win` pulse, state 2; after 2 ticks → `respawn`, state 1, `time_left`=30.
- Three `frog_hit` events across rounds → `lives` 2,1 then `lose` pulse with `lives`=0, state 3; next start edge → state 1, `lives`=3.
- `frog_hit` and `frog_home` same cycle → `lives` decrements, `win` stays 0.
- Timer build: 30 ticks with no events → death on 30th tick, `lives`=2; macro undefined: 40 ticks → no death, `time_left`=30.
- `win` followed by `game_over`=1 next cycle → state 4 before any `respawn`; start edge → state 1, new game.

Source files
------------

// File: rtl/frogger_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// frogger_round_ctrl_if
//   Signal bundle between the Frogger round sequencer and the game around it.
//   Names are written from the sequencer's point of view (i_ = into it,
//   o_ = out of it).
//
//   Parameters : LIVES, ROUND_TICKS (set the lives / time_left widths)
//   Modports   : slave  - the round sequencer
//                master - the game logic / score block that drives events
//   Signals    : i_start, i_tick, i_frog_home, i_frog_hit, i_game_over
//                o_win, o_lose, o_respawn, o_play_en, o_lives, o_time_left,
//                o_state
// ---------------------------------------------------------------------------
interface frogger_round_ctrl_if #(
    parameter int LIVES       = 3,
    parameter int ROUND_TICKS = 30
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = $clog2(ROUND_TICKS + 1);

    logic          i_start;
    logic          i_tick;
    logic          i_frog_home;
    logic          i_frog_hit;
    logic          i_game_over;
    logic          o_win;
    logic          o_lose;
    logic          o_respawn;
    logic          o_play_en;
    logic [LW-1:0] o_lives;
    logic [TW-1:0] o_time_left;
    logic [2:0]    o_state;

    modport slave (
        input  i_start, i_tick, i_frog_home, i_frog_hit, i_game_over,
        output o_win, o_lose, o_respawn, o_play_en, o_lives, o_time_left, o_state
    );

    modport master (
        output i_start, i_tick, i_frog_home, i_frog_hit, i_game_over,
        input  o_win, o_lose, o_respawn, o_play_en, o_lives, o_time_left, o_state
    );
endinterface

// File: rtl/frogger_round_ctrl.sv
// ---------------------------------------------------------------------------
// frogger_round_ctrl
//   Round / life sequencer for Frogger. Converts frog events into single-cycle
//   win / lose pulses for the score block, tracks lives and the per-round
//   countdown, sequences respawns and restarts the game on a start-key edge.
//
//   Ports:
//     i_clock  - system clock (CLOCK_50)
//     i_reset  - asynchronous, active-low reset
//     bus      - frogger_round_ctrl_if.slave (events in, pulses/status out)
//
//   Optional feature: define FROGGER_ROUND_TIMER_EN to build the round
//   countdown and timeout death. Without it time_left is held at ROUND_TICKS
//   and only frog_hit kills the frog.
// ---------------------------------------------------------------------------
module frogger_round_ctrl #(
    parameter int LIVES       = 3,
    parameter int ROUND_TICKS = 30,
    parameter int HOLD_TICKS  = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    frogger_round_ctrl_if.slave bus
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int TW = $clog2(ROUND_TICKS + 1);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HOLD = 3'd2,
        ST_DEAD = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    state_t        r_state,    w_state_next;
    logic [LW-1:0] r_lives,    w_lives_next;
    logic [HW-1:0] r_hold_cnt, w_hold_next;
    logic          r_start_q;
    logic          r_win,      w_win_next;
    logic          r_lose,     w_lose_next;
    logic          r_respawn,  w_respawn_next;
    logic          r_play_en;
    logic          w_go;
    logic          w_timeout;
    logic          w_death;

    assign w_go = bus.i_start & ~r_start_q;

`ifdef FROGGER_ROUND_TIMER_EN
    logic [TW-1:0] r_time_left, w_time_next;
    // Death fires on the tick that would take the count to zero, so the
    // counter reloads instead of ever showing 0 in PLAY.
    assign w_timeout = bus.i_tick && (r_time_left == TW'(1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_death = bus.i_frog_hit | w_timeout;

    always_comb begin
        w_state_next   = r_state;
        w_lives_next   = r_lives;
        w_hold_next    = r_hold_cnt;
        w_win_next     = 1'b0;
        w_lose_next    = 1'b0;
        w_respawn_next = 1'b0;
`ifdef FROGGER_ROUND_TIMER_EN
        w_time_next    = r_time_left;
`endif
        case (r_state)
            ST_PLAY: begin
                if (w_death) begin
                    // Death outranks reaching home in the same cycle.
                    if (r_lives == LW'(1)) begin
                        w_lives_next = '0;
                        w_lose_next  = 1'b1;
                        w_state_next = ST_DEAD;
                    end else begin
                        w_lives_next = r_lives - LW'(1);
                        w_hold_next  = '0;
                        w_state_next = ST_HOLD;
                    end
`ifdef FROGGER_ROUND_TIMER_EN
                    if (w_timeout)
                        w_time_next = TW'(ROUND_TICKS);
`endif
                end else if (bus.i_frog_home) begin
                    w_win_next   = 1'b1;
                    w_hold_next  = '0;
                    w_state_next = ST_HOLD;
                end
`ifdef FROGGER_ROUND_TIMER_EN
                else if (bus.i_tick) begin
                    w_time_next = r_time_left - TW'(1);
                end
`endif
            end
            ST_HOLD: begin
                // game_over arrives one cycle after the win; catching it here
                // first stops the tenth win from respawning the frog.
                if (bus.i_game_over) begin
                    w_state_next = ST_OVER;
                end else if (bus.i_tick) begin
                    if (r_hold_cnt == HW'(HOLD_TICKS - 1)) begin
                        w_hold_next    = '0;
                        w_respawn_next = 1'b1;
                        w_state_next   = ST_PLAY;
`ifdef FROGGER_ROUND_TIMER_EN
                        w_time_next    = TW'(ROUND_TICKS);
`endif
                    end else begin
                        w_hold_next = r_hold_cnt + HW'(1);
                    end
                end
            end
            default: begin
                // IDLE, DEAD and OVER all wait for a start edge to begin a game.
                if (w_go) begin
                    w_lives_next   = LW'(LIVES);
                    w_hold_next    = '0;
                    w_respawn_next = 1'b1;
                    w_state_next   = ST_PLAY;
`ifdef FROGGER_ROUND_TIMER_EN
                    w_time_next    = TW'(ROUND_TICKS);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_lives    <= LW'(LIVES);
            r_hold_cnt <= '0;
            // A key held through reset must not count as a start edge.
            r_start_q  <= 1'b1;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
            r_respawn  <= 1'b0;
            r_play_en  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lives    <= w_lives_next;
            r_hold_cnt <= w_hold_next;
            r_start_q  <= bus.i_start;
            r_win      <= w_win_next;
            r_lose     <= w_lose_next;
            r_respawn  <= w_respawn_next;
            r_play_en  <= (w_state_next == ST_PLAY);
        end
    end

`ifdef FROGGER_ROUND_TIMER_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            r_time_left <= TW'(ROUND_TICKS);
        else
            r_time_left <= w_time_next;
    end
    assign bus.o_time_left = r_time_left;
`else
    assign bus.o_time_left = TW'(ROUND_TICKS);
`endif

    assign bus.o_win     = r_win;
    assign bus.o_lose    = r_lose;
    assign bus.o_respawn = r_respawn;
    assign bus.o_play_en = r_play_en;
    assign bus.o_lives   = r_lives;
    assign bus.o_state   = r_state;
endmodule

// File: tb/tb_frogger_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frogger_round_ctrl
//   Table-driven bench for frogger_round_ctrl. Each table row holds the inputs
//   for one or more cycles and the outputs expected after the last of them.
//   The driver pushes expectations into a scoreboard queue as it drives; a
//   monitor pops and compares them 1 ns after each rising edge. Reset-time and
//   mid-game reset behaviour are checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_frogger_round_ctrl;
`ifdef FROGGER_ROUND_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    typedef struct {
        int   rep;
        logic st, tk, hm, ht, go;
        logic w, l, r, p;
        int   lv, tl, s;
    } vec_t;

    typedef struct {
        bit   chk;
        int   idx;
        vec_t v;
    } sb_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];
    sb_t  sb[$];

    frogger_round_ctrl_if #(.LIVES(3), .ROUND_TICKS(30)) bus ();

    frogger_round_ctrl #(.LIVES(3), .ROUND_TICKS(30), .HOLD_TICKS(2)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int rep, logic st, logic tk, logic hm, logic ht, logic go,
                                logic w, logic l, logic r, logic p, int lv, int tl, int s);
        vec_t v;
        v.rep = rep; v.st = st; v.tk = tk; v.hm = hm; v.ht = ht; v.go = go;
        v.w = w; v.l = l; v.r = r; v.p = p; v.lv = lv; v.tl = tl; v.s = s;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d actual %0d required %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, int idx, logic w, logic l, logic r, logic p,
                            int lv, int tl, int s);
        chk({tag, "_win"},     idx, 32'(bus.o_win),       32'(w));
        chk({tag, "_lose"},    idx, 32'(bus.o_lose),      32'(l));
        chk({tag, "_respawn"}, idx, 32'(bus.o_respawn),   32'(r));
        chk({tag, "_play_en"}, idx, 32'(bus.o_play_en),   32'(p));
        chk({tag, "_lives"},   idx, 32'(bus.o_lives),     32'(lv));
        chk({tag, "_time"},    idx, 32'(bus.o_time_left), 32'(tl));
        chk({tag, "_state"},   idx, 32'(bus.o_state),     32'(s));
    endtask

    // Monitor: one scoreboard entry per clock edge while the table runs.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("win_lose_excl", e.idx, 32'(bus.o_win & bus.o_lose), 32'd0);
            if (e.chk) begin
                chk_outs("tbl", e.idx, e.v.w, e.v.l, e.v.r, e.v.p, e.v.lv, e.v.tl, e.v.s);
                $display("vec %0d state=%0d lives=%0d time=%0d win=%0b lose=%0b respawn=%0b play=%0b",
                         e.idx, bus.o_state, bus.o_lives, bus.o_time_left,
                         bus.o_win, bus.o_lose, bus.o_respawn, bus.o_play_en);
            end
        end
    end

    task automatic drive(logic st, logic tk, logic hm, logic ht, logic go);
        bus.i_start     = st;
        bus.i_tick      = tk;
        bus.i_frog_home = hm;
        bus.i_frog_hit  = ht;
        bus.i_game_over = go;
    endtask

    initial begin
        sb_t e;
        int  tl_a;
        int  lv_b;

        // inputs: rep, start, tick, home, hit, game_over
        // expect: win, lose, respawn, play_en, lives, time_left, state
        tl_a = TIMER ? 29 : 30;
        lv_b = TIMER ? 2 : 3;
        vt.push_back(mk(2,  1,0,0,0,0, 0,0,0,0, 3,30,0));   // start held after reset
        vt.push_back(mk(1,  0,0,0,0,0, 0,0,0,0, 3,30,0));
        vt.push_back(mk(1,  1,0,0,0,0, 0,0,1,1, 3,30,1));   // start edge -> new game
        vt.push_back(mk(1,  1,0,0,0,0, 0,0,0,1, 3,30,1));   // respawn is one cycle
        vt.push_back(mk(1,  1,0,1,0,0, 1,0,0,0, 3,30,2));   // home -> win
        vt.push_back(mk(1,  1,0,1,0,0, 0,0,0,0, 3,30,2));   // home ignored in HOLD
        vt.push_back(mk(1,  0,1,0,0,0, 0,0,0,0, 3,30,2));   // first hold tick
        vt.push_back(mk(1,  0,1,0,0,0, 0,0,1,1, 3,30,1));   // second -> respawn
        vt.push_back(mk(1,  0,0,0,0,0, 0,0,0,1, 3,30,1));
        vt.push_back(mk(1,  0,1,0,0,0, 0,0,0,1, 3,tl_a,1)); // countdown tick
        vt.push_back(mk(1,  0,0,0,1,0, 0,0,0,0, 2,tl_a,2)); // hit -> lives 2
        vt.push_back(mk(1,  0,0,0,1,0, 0,0,0,0, 2,tl_a,2)); // hit ignored in HOLD
        vt.push_back(mk(2,  0,1,0,0,0, 0,0,1,1, 2,30,1));
        vt.push_back(mk(1,  0,0,1,1,0, 0,0,0,0, 1,30,2));   // hit+home: death wins
        vt.push_back(mk(2,  0,1,0,0,0, 0,0,1,1, 1,30,1));
        vt.push_back(mk(1,  0,0,0,1,0, 0,1,0,0, 0,30,3));   // last life -> lose
        vt.push_back(mk(1,  0,0,0,0,0, 0,0,0,0, 0,30,3));   // lose is one cycle
        vt.push_back(mk(1,  1,0,0,0,0, 0,0,1,1, 3,30,1));   // restart from DEAD
        vt.push_back(mk(1,  0,0,0,0,0, 0,0,0,1, 3,30,1));
        vt.push_back(mk(29, 0,1,0,0,0, 0,0,0,1, 3,TIMER ? 1 : 30,1));
        vt.push_back(mk(1,  0,1,0,0,0, 0,0,0,!TIMER, lv_b,30,TIMER ? 2 : 1)); // 30th tick
        vt.push_back(mk(10, 0,1,0,0,0, 0,0,0,1, lv_b,TIMER ? 22 : 30,1));
        vt.push_back(mk(1,  0,0,1,0,0, 1,0,0,0, lv_b,TIMER ? 22 : 30,2));
        vt.push_back(mk(1,  0,0,0,0,1, 0,0,0,0, lv_b,TIMER ? 22 : 30,4));   // game over
        vt.push_back(mk(3,  0,1,0,0,1, 0,0,0,0, lv_b,TIMER ? 22 : 30,4));   // no respawn
        vt.push_back(mk(1,  0,0,0,0,0, 0,0,0,0, lv_b,TIMER ? 22 : 30,4));
        vt.push_back(mk(1,  1,0,0,0,0, 0,0,1,1, 3,30,1));   // restart from OVER
        vt.push_back(mk(1,  1,0,0,1,0, 0,0,0,0, 2,30,2));   // mid-game state for reset test

        // Reset low for five cycles with the start key held.
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk_outs("rst", -1, 0, 0, 0, 0, 3, 30, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            for (int k = 0; k < vt[i].rep; k++) begin
                @(negedge clk);
                drive(vt[i].st, vt[i].tk, vt[i].hm, vt[i].ht, vt[i].go);
                e.chk = (k == vt[i].rep - 1);
                e.idx = i;
                e.v   = vt[i];
                sb.push_back(e);
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sb_drained", -1, 32'(sb.size()), 32'd0);

        // Mid-game asynchronous reset: immediate return to IDLE, no pulses.
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("midrst", -2, 0, 0, 0, 0, 3, 30, 0);
        bus.i_start = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_outs("rel", -3, 0, 0, 0, 0, 3, 30, 0);
        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        chk_outs("restart", -4, 0, 0, 1, 1, 3, 30, 1);
        $display("restart state=%0d lives=%0d respawn=%0b", bus.o_state, bus.o_lives, bus.o_respawn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
